// File: rtl/lsu_serial_pkg.sv
// Shared state encoding and funct3 decoding for the serial load/store unit.
package lsu_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Access size in bytes; bit 2 (signedness) does not affect the size.
    function automatic logic [3:0] f3_size_bytes(input logic [2:0] funct3);
        logic [3:0] size;
        case (funct3[1:0])
            2'b00:   size = 4'd1;
            2'b01:   size = 4'd2;
            2'b10:   size = 4'd4;
            default: size = 4'd8;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of a little-endian load value of 1, 2, 4 or 8 bytes to XLEN.
module lsu_extend #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] raw_i,
    input  logic [3:0]      size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] ext_o
);

    logic msb;
    logic fill;

    always_comb begin
        case (size_i)
            4'd1:    msb = raw_i[7];
            4'd2:    msb = raw_i[15];
            4'd4:    msb = raw_i[31];
            default: msb = raw_i[XLEN-1];
        endcase
        fill  = msb & ~unsigned_i;
        ext_o = raw_i;
        for (int b = 0; b < XLEN / 8; b++) begin
            if (b >= int'(size_i)) begin
                ext_o[8*b +: 8] = {8{fill}};
            end
        end
    end

endmodule

// File: rtl/lsu_serial.sv
// Multi-cycle load/store unit: splits any RISC-V LOAD/STORE into BUS_BYTES-wide
// beats on a narrow asynchronous-read memory port, one beat per clock.
module lsu_serial
    import lsu_serial_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int BUS_BYTES        = 1,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_write_i,
    input  logic [2:0]             req_funct3_i,
    input  logic [ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [XLEN-1:0]        req_wdata_i,
    output logic                   resp_valid_o,
    output logic                   resp_error_o,
    output logic [XLEN-1:0]        resp_rdata_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    output logic                   mem_we_o,
    output logic [BUS_BYTES-1:0]   mem_be_o,
    output logic [8*BUS_BYTES-1:0] mem_wdata_o,
    input  logic [8*BUS_BYTES-1:0] mem_rdata_i
);

    localparam int XBYTES = XLEN / 8;
    localparam int BUS_SH = $clog2(BUS_BYTES);

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [XLEN-1:0]       asm_q, asm_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  write_q, write_d;
    logic                  error_q, error_d;
    logic [3:0]            beat_q, beat_d;

    logic [3:0]            size_q;
    logic [3:0]            n_beats;
    logic [3:0]            beat_off;
    logic [3:0]            req_size;
    logic                  bad_f3;
    logic                  req_illegal;
    logic [XLEN-1:0]       ext_data;

    assign size_q   = f3_size_bytes(funct3_q);
    assign n_beats  = (size_q + 4'(BUS_BYTES - 1)) >> BUS_SH;
    assign beat_off = beat_q << BUS_SH;

    always_comb begin
        req_size = f3_size_bytes(req_funct3_i);
        case (req_funct3_i)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: bad_f3 = 1'b0;
            F3_D, F3_WU:                    bad_f3 = (XLEN == 32);
            default:                        bad_f3 = 1'b1;
        endcase
        // Stores have no unsigned variants, so funct3[2] on a store is illegal.
        req_illegal = bad_f3 | (req_write_i & req_funct3_i[2]);
        if (ALLOW_MISALIGNED == 0) begin
            req_illegal = req_illegal
                        | ((req_addr_i[2:0] & (req_size[2:0] - 3'd1)) != 3'd0);
        end
    end

    lsu_extend #(.XLEN(XLEN)) u_extend (
        .raw_i      (asm_q),
        .size_i     (size_q),
        .unsigned_i (funct3_q[2]),
        .ext_o      (ext_data)
    );

    // NOTE: every output and _d is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        asm_d        = asm_q;
        funct3_d     = funct3_q;
        write_d      = write_q;
        error_d      = error_q;
        beat_d       = beat_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_error_o = 1'b0;
        resp_rdata_o = '0;
        mem_addr_o   = '0;
        mem_we_o     = 1'b0;
        mem_be_o     = '0;
        mem_wdata_o  = '0;

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    funct3_d = req_funct3_i;
                    write_d  = req_write_i;
                    error_d  = req_illegal;
                    beat_d   = '0;
                    asm_d    = '0;
                    state_d  = req_illegal ? RESP : BEAT;
                end
            end

            BEAT: begin
                mem_addr_o = addr_q + ADDR_WIDTH'(beat_off);
                mem_we_o   = write_q;
                for (int j = 0; j < BUS_BYTES; j++) begin
                    if (int'(beat_off) + j < int'(size_q)) begin
                        mem_be_o[j] = 1'b1;
                    end
                end
                // Lane j of this beat carries request byte beat_off + j.
                for (int b = 0; b < XBYTES; b++) begin
                    for (int j = 0; j < BUS_BYTES; j++) begin
                        if (mem_be_o[j] && (int'(beat_off) + j == b)) begin
                            if (write_q) begin
                                mem_wdata_o[8*j +: 8] = wdata_q[8*b +: 8];
                            end else begin
                                asm_d[8*b +: 8] = mem_rdata_i[8*j +: 8];
                            end
                        end
                    end
                end
                if (beat_q == n_beats - 4'd1) begin
                    state_d = RESP;
                end else begin
                    beat_d = beat_q + 4'd1;
                end
            end

            RESP: begin
                resp_valid_o = 1'b1;
                resp_error_o = error_q;
                if (!write_q && !error_q) begin
                    resp_rdata_o = ext_data;
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            asm_q    <= '0;
            funct3_q <= '0;
            write_q  <= 1'b0;
            error_q  <= 1'b0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            asm_q    <= asm_d;
            funct3_q <= funct3_d;
            write_q  <= write_d;
            error_q  <= error_d;
            beat_q   <= beat_d;
        end
    end

endmodule

// File: tb/tb_lsu_serial.sv
// Scoreboard bench for lsu_serial: four parameter variants, byte-addressed memory models,
// directed requests with hand-computed beats and responses.
module tb_lsu_serial;
    import lsu_serial_pkg::*;

    localparam int NI = 4;

    typedef struct packed {
        int          inst;
        logic [31:0] addr;
        logic        we;
        logic [7:0]  be;
        logic [63:0] wd;
        int          rel;
    } beat_t;

    typedef struct packed {
        int          inst;
        logic        err;
        logic [63:0] rdata;
        int          rel;
    } resp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid  [NI];
    logic        req_write  [NI];
    logic [2:0]  req_funct3 [NI];
    logic [31:0] req_addr   [NI];
    logic [63:0] req_wdata  [NI];
    wire         req_ready  [NI];
    wire         resp_valid [NI];
    wire         resp_error [NI];
    wire  [63:0] resp_rdata [NI];
    wire  [31:0] mem_addr   [NI];
    wire         mem_we     [NI];
    wire  [7:0]  mem_be     [NI];
    wire  [63:0] mem_wdata  [NI];
    logic [63:0] mem_rdata  [NI];

    // 0: XLEN32/BUS1/misaligned ok  1: XLEN32/BUS1/strict  2: XLEN64/BUS4  3: XLEN32/BUS4
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int XL = (g == 2) ? 64 : 32;
        localparam int BB = (g >= 2) ? 4 : 1;
        localparam int AM = (g == 1) ? 0 : 1;
        wire [XL-1:0]   rdata;
        wire [BB-1:0]   be;
        wire [8*BB-1:0] wdata;

        lsu_serial #(
            .XLEN(XL), .ADDR_WIDTH(32), .BUS_BYTES(BB), .ALLOW_MISALIGNED(AM)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .req_valid_i  (req_valid[g]),
            .req_ready_o  (req_ready[g]),
            .req_write_i  (req_write[g]),
            .req_funct3_i (req_funct3[g]),
            .req_addr_i   (req_addr[g]),
            .req_wdata_i  (req_wdata[g][XL-1:0]),
            .resp_valid_o (resp_valid[g]),
            .resp_error_o (resp_error[g]),
            .resp_rdata_o (rdata),
            .mem_addr_o   (mem_addr[g]),
            .mem_we_o     (mem_we[g]),
            .mem_be_o     (be),
            .mem_wdata_o  (wdata),
            .mem_rdata_i  (mem_rdata[g][8*BB-1:0])
        );

        assign resp_rdata[g] = 64'(rdata);
        assign mem_be[g]     = 8'(be);
        assign mem_wdata[g]  = 64'(wdata);
    end

    // Byte memories, 4 KiB each, indexed by the low 12 address bits.
    logic [7:0] mem [NI][4096];
    logic       mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int g = 0; g < NI; g++) begin
                for (int a = 0; a < 4096; a++) mem[g][a] <= 8'h00;
                mem[g][12'h080] <= 8'hF0;
                mem[g][12'h101] <= 8'h34;
                mem[g][12'h102] <= 8'h82;
                for (int k = 0; k < 8; k++) mem[g][12'h200 + 12'(k)] <= 8'(k + 1);
            end
            mem_loaded <= 1'b1;
        end else begin
            for (int g = 0; g < NI; g++) begin
                if (mem_we[g]) begin
                    for (int j = 0; j < 8; j++) begin
                        if (mem_be[g][j]) mem[g][12'(mem_addr[g] + 32'(j))] <= mem_wdata[g][8*j +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int g = 0; g < NI; g++) begin
            for (int j = 0; j < 8; j++) begin
                mem_rdata[g][8*j +: 8] = mem[g][12'(mem_addr[g] + 32'(j))];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    n_pass  = 0;
    int    n_total = 0;
    int    last_acc = 0;
    beat_t bq [$];
    resp_t rq [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops expectations whenever a DUT presents a beat or a response.
    logic        resp_seen [NI];
    beat_t       mon_b;
    resp_t       mon_r;
    logic [63:0] mon_mask;

    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (rst) begin
                resp_seen[g] = 1'b0;
                check("rst_req_ready", 64'(req_ready[g]), 64'd1);
                check("rst_resp_valid", 64'(resp_valid[g]), 64'd0);
                check("rst_mem_we", 64'(mem_we[g]), 64'd0);
                check("rst_mem_be", 64'(mem_be[g]), 64'd0);
                check("rst_mem_addr", 64'(mem_addr[g]), 64'd0);
            end else begin
                if (resp_seen[g]) begin
                    check("ready_after_resp", 64'(req_ready[g]), 64'd1);
                    check("resp_single_pulse", 64'(resp_valid[g]), 64'd0);
                end
                resp_seen[g] = resp_valid[g];
                if (mem_be[g] != 8'h00 || mem_we[g]) begin
                    check("beat_expected", 64'(bq.size() != 0), 64'd1);
                    if (bq.size() != 0) begin
                        mon_b = bq.pop_front();
                        for (int j = 0; j < 8; j++) mon_mask[8*j +: 8] = {8{mon_b.be[j]}};
                        check("beat_instance", 64'(g), 64'(mon_b.inst));
                        check("beat_cycle", 64'(cyc - last_acc), 64'(mon_b.rel));
                        check("mem_addr", 64'(mem_addr[g]), 64'(mon_b.addr));
                        check("mem_we", 64'(mem_we[g]), 64'(mon_b.we));
                        check("mem_be", 64'(mem_be[g]), 64'(mon_b.be));
                        check("beat_req_ready", 64'(req_ready[g]), 64'd0);
                        if (mon_b.we) check("mem_wdata", mem_wdata[g] & mon_mask, mon_b.wd & mon_mask);
                    end
                end
                if (resp_valid[g]) begin
                    check("resp_expected", 64'(rq.size() != 0), 64'd1);
                    if (rq.size() != 0) begin
                        mon_r = rq.pop_front();
                        check("resp_instance", 64'(g), 64'(mon_r.inst));
                        check("resp_cycle", 64'(cyc - last_acc), 64'(mon_r.rel));
                        check("resp_error", 64'(resp_error[g]), 64'(mon_r.err));
                        check("resp_rdata", resp_rdata[g], mon_r.rdata);
                        check("resp_req_ready", 64'(req_ready[g]), 64'd0);
                    end
                end
            end
        end
    end

    task automatic eb(input int g, input logic [31:0] addr, input logic we, input logic [7:0] be,
                      input logic [63:0] wd, input int rel);
        beat_t e;
        e.inst = g; e.addr = addr; e.we = we; e.be = be; e.wd = wd; e.rel = rel;
        bq.push_back(e);
    endtask

    task automatic wait_ready(input int g);
        int n = 0;
        @(negedge clk);
        while (!(req_ready[g] && rq.size() == 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", 64'(n < 50), 64'd1);
    endtask

    task automatic issue(input int g, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [63:0] wd, input logic err, input logic [63:0] rd, input int n);
        resp_t r;
        wait_ready(g);
        r.inst = g; r.err = err; r.rdata = rd; r.rel = n;
        rq.push_back(r);
        req_valid[g] = 1'b1; req_write[g] = wr; req_funct3[g] = f3;
        req_addr[g] = addr; req_wdata[g] = wd;
        @(posedge clk);
        #1;
        last_acc = cyc;
        // Scramble the request inputs: the unit must work from its latched copy.
        req_valid[g] = 1'b0; req_write[g] = ~wr; req_funct3[g] = ~f3;
        req_addr[g] = ~addr; req_wdata[g] = ~wd;
    endtask

    initial begin
        rst = 1'b1;
        for (int g = 0; g < NI; g++) begin
            req_valid[g] = 1'b0; req_write[g] = 1'b0; req_funct3[g] = 3'b000;
            req_addr[g] = '0; req_wdata[g] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // SW misaligned on a byte bus: four byte beats, response in cycle 5.
        eb(0, 32'h79, 1, 8'h01, 64'h78, 0);
        eb(0, 32'h7A, 1, 8'h01, 64'h56, 1);
        eb(0, 32'h7B, 1, 8'h01, 64'h34, 2);
        eb(0, 32'h7C, 1, 8'h01, 64'h12, 3);
        issue(0, 1'b1, F3_W, 32'h79, 64'h12345678, 1'b0, 64'h0, 4);

        // LB / LBU of 0xF0.
        eb(0, 32'h80, 0, 8'h01, 64'h0, 0);
        issue(0, 1'b0, F3_B, 32'h80, 64'h0, 1'b0, 64'hFFFF_FFF0, 1);
        eb(0, 32'h80, 0, 8'h01, 64'h0, 0);
        issue(0, 1'b0, F3_BU, 32'h80, 64'h0, 1'b0, 64'h0000_00F0, 1);

        // LH / LHU misaligned, allowed.
        eb(0, 32'h101, 0, 8'h01, 64'h0, 0);
        eb(0, 32'h102, 0, 8'h01, 64'h0, 1);
        issue(0, 1'b0, F3_H, 32'h101, 64'h0, 1'b0, 64'hFFFF_8234, 2);
        eb(0, 32'h101, 0, 8'h01, 64'h0, 0);
        eb(0, 32'h102, 0, 8'h01, 64'h0, 1);
        issue(0, 1'b0, F3_HU, 32'h101, 64'h0, 1'b0, 64'h0000_8234, 2);

        // Strict alignment: misaligned LH and SW error out with no beats; aligned LH works.
        issue(1, 1'b0, F3_H, 32'h101, 64'h0, 1'b1, 64'h0, 0);
        issue(1, 1'b1, F3_W, 32'h102, 64'hDEAD_BEEF, 1'b1, 64'h0, 0);
        eb(1, 32'h102, 0, 8'h01, 64'h0, 0);
        eb(1, 32'h103, 0, 8'h01, 64'h0, 1);
        issue(1, 1'b0, F3_H, 32'h102, 64'h0, 1'b0, 64'h0000_0082, 2);

        // Illegal funct3 for XLEN=32, reserved 111, and store with funct3[2]=1.
        issue(0, 1'b0, F3_D, 32'h0, 64'h0, 1'b1, 64'h0, 0);
        issue(0, 1'b0, F3_WU, 32'h0, 64'h0, 1'b1, 64'h0, 0);
        issue(0, 1'b0, 3'b111, 32'h0, 64'h0, 1'b1, 64'h0, 0);
        issue(0, 1'b1, F3_BU, 32'h0, 64'h55, 1'b1, 64'h0, 0);

        // XLEN=64 on a 4-byte bus.
        eb(2, 32'h200, 0, 8'h0F, 64'h0, 0);
        eb(2, 32'h204, 0, 8'h0F, 64'h0, 1);
        issue(2, 1'b0, F3_D, 32'h200, 64'h0, 1'b0, 64'h0807_0605_0403_0201, 2);
        eb(2, 32'h204, 0, 8'h0F, 64'h0, 0);
        issue(2, 1'b0, F3_WU, 32'h204, 64'h0, 1'b0, 64'h0000_0000_0807_0605, 1);
        eb(2, 32'h208, 1, 8'h0F, 64'h5566_7788, 0);
        eb(2, 32'h20C, 1, 8'h0F, 64'h1122_3344, 1);
        issue(2, 1'b1, F3_D, 32'h208, 64'h1122_3344_5566_7788, 1'b0, 64'h0, 2);
        eb(2, 32'h208, 0, 8'h01, 64'h0, 0);
        issue(2, 1'b0, F3_B, 32'h208, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FF88, 1);
        eb(2, 32'h208, 0, 8'h0F, 64'h0, 0);
        eb(2, 32'h20C, 0, 8'h0F, 64'h0, 1);
        issue(2, 1'b0, F3_D, 32'h208, 64'h0, 1'b0, 64'h1122_3344_5566_7788, 2);

        // 4-byte bus, XLEN=32: SH single beat with partial lanes, then read back.
        eb(3, 32'h300, 1, 8'h03, 64'hABCD, 0);
        issue(3, 1'b1, F3_H, 32'h300, 64'hFFFF_ABCD, 1'b0, 64'h0, 1);
        eb(3, 32'h300, 0, 8'h0F, 64'h0, 0);
        issue(3, 1'b0, F3_W, 32'h300, 64'h0, 1'b0, 64'h0000_ABCD, 1);
        eb(3, 32'h301, 0, 8'h03, 64'h0, 0);
        issue(3, 1'b0, F3_H, 32'h301, 64'h0, 1'b0, 64'h0000_00AB, 1);

        // Address wrap on store and load.
        eb(0, 32'hFFFF_FFFE, 1, 8'h01, 64'hD4, 0);
        eb(0, 32'hFFFF_FFFF, 1, 8'h01, 64'hC3, 1);
        eb(0, 32'h0000_0000, 1, 8'h01, 64'hB2, 2);
        eb(0, 32'h0000_0001, 1, 8'h01, 64'hA1, 3);
        issue(0, 1'b1, F3_W, 32'hFFFF_FFFE, 64'hA1B2_C3D4, 1'b0, 64'h0, 4);
        eb(0, 32'hFFFF_FFFF, 0, 8'h01, 64'h0, 0);
        eb(0, 32'h0000_0000, 0, 8'h01, 64'h0, 1);
        eb(0, 32'h0000_0001, 0, 8'h01, 64'h0, 2);
        eb(0, 32'h0000_0002, 0, 8'h01, 64'h0, 3);
        issue(0, 1'b0, F3_W, 32'hFFFF_FFFF, 64'h0, 1'b0, 64'h00A1_B2C3, 4);

        // Reset during the second beat of an LW: no response, then a normal LB.
        eb(0, 32'h80, 0, 8'h01, 64'h0, 0);
        wait_ready(0);
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_funct3[0] = F3_W;
        req_addr[0] = 32'h80; req_wdata[0] = '0;
        @(posedge clk);
        #1;
        last_acc = cyc;
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("abort_beats_consumed", 64'(bq.size()), 64'd0);
        eb(0, 32'h80, 0, 8'h01, 64'h0, 0);
        issue(0, 1'b0, F3_B, 32'h80, 64'h0, 1'b0, 64'hFFFF_FFF0, 1);

        wait_ready(0);
        repeat (3) @(negedge clk);
        check("beat_queue_drained", 64'(bq.size()), 64'd0);
        check("resp_queue_drained", 64'(rq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: summary not reached within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lsu_serial.md
Name: lsu_serial

Overview:
Parametrised multi-cycle load/store unit that replaces the 32-bit-only memory access path of the control FSM. It executes all RISC-V LOAD/STORE widths (byte, half, word, and double when XLEN=64) over a narrow memory port of BUS_BYTES lanes, one beat per clock. Loads are sign- or zero-extended as funct3 selects. It sits between the control FSM (READ_MEMORY/WRITE_MEMORY states) and Ram. It reports misaligned or illegal requests instead of accessing memory.

Parameters:
XLEN, 32, register width; legal values 32 or 64.
ADDR_WIDTH, 32, byte-address width.
BUS_BYTES, 1, memory port width in bytes; legal values 1, 2, 4, 8; must be ≤ XLEN/8.
ALLOW_MISALIGNED, 1, 1 = any address is accepted; 0 = an address not aligned to the access size raises an error.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 of the LOAD/STORE instruction
req_addr  in  ADDR_WIDTH  effective byte address (already computed by the ALU)
req_wdata  in  XLEN  store data, taken from rs2
resp_valid  out  1  one-cycle completion pulse
resp_error  out  1  qualified by resp_valid: misaligned access or illegal funct3
resp_rdata  out  XLEN  extended load data; 0 for stores and errors
mem_addr  out  ADDR_WIDTH  byte address of lane 0 for the current beat
mem_we  out  1  write strobe for the current beat
mem_be  out  BUS_BYTES  byte-lane enables
mem_wdata  out  8*BUS_BYTES  write lanes
mem_rdata  in  8*BUS_BYTES  read lanes; asynchronous read, valid in the same cycle as mem_addr

Behaviour:
- Reset values, applied asynchronously: state=IDLE, req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0. All internal registers clear.
- States:
  - IDLE: req_ready=1. A request is accepted on an edge where req_valid=1. On accept, latch addr, wdata, funct3 and write, then go to BEAT. If the request is illegal, go to RESP with the error flag set.
  - BEAT: req_ready=0. Issue one beat per cycle. After the last beat, go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then return to IDLE.
- Request size S in bytes: funct3[1:0] gives 00=1, 01=2, 10=4, 11=8.
- Illegal requests (error):
  - 011 or 110 when XLEN=32.
  - 111 in any mode.
  - Store with funct3[2]=1.
  - Misaligned address (addr % S ≠ 0) when ALLOW_MISALIGNED=0.
- An illegal request produces no memory activity: mem_we and mem_be stay 0. resp_valid rises in the cycle after accept.
- Beat count N = ceil(S/BUS_BYTES). Beat k, for k = 0..N-1:
  - mem_addr = latched addr + k*BUS_BYTES, wrapping modulo 2^ADDR_WIDTH.
  - mem_be lane j = 1 iff k*BUS_BYTES + j < S.
- Byte order is little-endian.
- Store beat k: mem_we=1 and mem_wdata lane j = wdata byte (k*BUS_BYTES + j). mem_we is 0 in every other state and cycle.
- Load beat k: enabled mem_rdata lanes are captured at the clock edge into byte (k*BUS_BYTES + j) of an XLEN assembly register.
- Load extension in RESP:
  - Sign-extend from bit 8*S-1 when funct3[2]=0.
  - Zero-extend when funct3[2]=1 (LBU, LHU, LWU).
- Latency: accept edge → N beat cycles → resp_valid in cycle N+1 after accept → req_ready=1 in cycle N+2. There is no back-to-back accept while in RESP.
- req_valid is ignored outside IDLE. The caller holds the request inputs stable only until accept.
- Reset asserted in any state returns the unit to IDLE immediately. No resp_valid is produced for the aborted request. Beats already written remain in memory.

Decomposition:
- Shared package (alongside OpCode/Instruction):
  - LsuState enum: IDLE, BEAT, RESP.
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_D=011, F3_BU=100, F3_HU=101, F3_WU=110.
  - Function f3_size_bytes(funct3).
- Sub-module lsu_extend (combinational): inputs raw XLEN data, size, unsigned flag; output is the extended XLEN value. It is reused later by the writeback path.

Test Plan:
1. Default parameters, SW addr=0x79 wdata=0x12345678. Required: 4 beats, mem_addr 0x79..0x7C, mem_wdata 78,56,34,12, mem_we=1 on each beat. resp_valid in cycle 5 with resp_error=0 and rdata=0.
2. Memory[0x80]=0xF0. LB 0x80 → resp_rdata=0xFFFFFFF0. LBU 0x80 → 0x000000F0. resp_valid in cycle 2 for both.
3. Memory[0x101]=0x34, memory[0x102]=0x82.
   - ALLOW_MISALIGNED=1: LH 0x101 → 0xFFFF8234.
   - ALLOW_MISALIGNED=0: the same LH gives resp_error=1 in cycle 1, with mem_be=0 throughout.
4. XLEN=32, funct3=011 → resp_error=1. XLEN=64, BUS_BYTES=4, LD 0x200 with memory 0x200..0x207 = 01..08 → 2 beats, resp_rdata=0x0807060504030201.
5. BUS_BYTES=4: SH 0x300 wdata=0xABCD → 1 beat, mem_be=0011, mem_wdata[15:0]=0xABCD. Address wrap: SW at 0xFFFFFFFE with BUS_BYTES=1 → beats at FFFFFFFE, FFFFFFFF, 00000000, 00000001.
6. Assert rst during the 2nd beat of LW → the same cycle shows mem_we=0 and req_ready=1. resp_valid never pulses. A following LB completes normally.
